// File: rtl/mem_rd_arbiter_pkg.sv
// Shared encodings for the memory read arbiter.
// Holds FSM states, grant codes and the burst lengths used by the caches.
package mem_rd_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_RSP  = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_IC   = 2'b01,
        GRANT_DC   = 2'b10
    } grant_t;

    localparam logic [7:0] LEN_BURST  = 8'd7;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Two-input round-robin picker for the I-Cache / D-Cache read requests.
// Ports: i_ic_valid, i_dc_valid, i_rr_ptr (last served) -> o_grant (one-hot).
module mem_rd_arbiter_rr_arb2
    import mem_rd_arbiter_pkg::*;
(
    input  logic   i_ic_valid,
    input  logic   i_dc_valid,
    input  grant_t i_rr_ptr,
    output grant_t o_grant
);

    always_comb begin
        o_grant = GRANT_NONE;
        if (i_ic_valid && i_dc_valid) begin
            // On a tie the requester that was not served last wins.
            o_grant = (i_rr_ptr == GRANT_IC) ? GRANT_DC : GRANT_IC;
        end else if (i_ic_valid) begin
            o_grant = GRANT_IC;
        end else if (i_dc_valid) begin
            o_grant = GRANT_DC;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Arbitrates I-Cache and D-Cache read channels onto one memory read channel.
// Ports: from_/to_ ic, dc and mem read req/rsp channels; sticky burst_err.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              from_ic_rd_req_valid,
    input  logic [ADDR_W-1:0] from_ic_rd_req_addr,
    input  logic [LEN_W-1:0]  from_ic_rd_req_len,
    output logic              to_ic_rd_req_ready,
    output logic              to_ic_rd_rsp_valid,
    output logic [DATA_W-1:0] to_ic_rd_rsp_data,
    output logic              to_ic_rd_rsp_last,
    input  logic              from_ic_rd_rsp_ready,
    input  logic              from_dc_rd_req_valid,
    input  logic [ADDR_W-1:0] from_dc_rd_req_addr,
    input  logic [LEN_W-1:0]  from_dc_rd_req_len,
    output logic              to_dc_rd_req_ready,
    output logic              to_dc_rd_rsp_valid,
    output logic [DATA_W-1:0] to_dc_rd_rsp_data,
    output logic              to_dc_rd_rsp_last,
    input  logic              from_dc_rd_rsp_ready,
    output logic              to_mem_rd_req_valid,
    output logic [ADDR_W-1:0] to_mem_rd_req_addr,
    output logic [LEN_W-1:0]  to_mem_rd_req_len,
    input  logic              from_mem_rd_req_ready,
    input  logic              from_mem_rd_rsp_valid,
    input  logic [DATA_W-1:0] from_mem_rd_rsp_data,
    input  logic              from_mem_rd_rsp_last,
    output logic              to_mem_rd_rsp_ready,
    output logic              burst_err
);

    state_t            r_state;
    state_t            w_state_nxt;
    grant_t            r_grant;
    grant_t            r_rr_ptr;
    grant_t            w_pick;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W:0]    r_beat_cnt;
    logic              r_burst_err;
    logic              w_hs;

    mem_rd_arbiter_rr_arb2 u_rr_arb2 (
        .i_ic_valid (from_ic_rd_req_valid),
        .i_dc_valid (from_dc_rd_req_valid),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_pick)
    );

    always_comb begin
        w_state_nxt         = r_state;
        w_hs                = 1'b0;
        to_ic_rd_req_ready  = 1'b0;
        to_dc_rd_req_ready  = 1'b0;
        to_ic_rd_rsp_valid  = 1'b0;
        to_ic_rd_rsp_data   = '0;
        to_ic_rd_rsp_last   = 1'b0;
        to_dc_rd_rsp_valid  = 1'b0;
        to_dc_rd_rsp_data   = '0;
        to_dc_rd_rsp_last   = 1'b0;
        to_mem_rd_req_valid = 1'b0;
        to_mem_rd_req_addr  = r_addr;
        to_mem_rd_req_len   = r_len;
        to_mem_rd_rsp_ready = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // Stale beats with no owner are accepted and dropped.
                to_mem_rd_rsp_ready = 1'b1;
                to_ic_rd_req_ready  = (w_pick == GRANT_IC);
                to_dc_rd_req_ready  = (w_pick == GRANT_DC);
                if (w_pick != GRANT_NONE) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                to_mem_rd_req_valid = 1'b1;
                if (from_mem_rd_req_ready) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (r_grant == GRANT_IC) begin
                    to_ic_rd_rsp_valid  = from_mem_rd_rsp_valid;
                    to_ic_rd_rsp_data   = from_mem_rd_rsp_data;
                    to_ic_rd_rsp_last   = from_mem_rd_rsp_last;
                    to_mem_rd_rsp_ready = from_ic_rd_rsp_ready;
                end else if (r_grant == GRANT_DC) begin
                    to_dc_rd_rsp_valid  = from_mem_rd_rsp_valid;
                    to_dc_rd_rsp_data   = from_mem_rd_rsp_data;
                    to_dc_rd_rsp_last   = from_mem_rd_rsp_last;
                    to_mem_rd_rsp_ready = from_dc_rd_rsp_ready;
                end
                w_hs = from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;
                if (w_hs && from_mem_rd_rsp_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // While reset is held nothing is granted or forwarded upstream.
        if (!rst) begin
            to_ic_rd_req_ready  = 1'b0;
            to_dc_rd_req_ready  = 1'b0;
            to_ic_rd_rsp_valid  = 1'b0;
            to_ic_rd_rsp_data   = '0;
            to_ic_rd_rsp_last   = 1'b0;
            to_dc_rd_rsp_valid  = 1'b0;
            to_dc_rd_rsp_data   = '0;
            to_dc_rd_rsp_last   = 1'b0;
            to_mem_rd_req_valid = 1'b0;
            to_mem_rd_rsp_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= GRANT_NONE;
            r_rr_ptr    <= GRANT_IC;
            r_addr      <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_burst_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_pick != GRANT_NONE) begin
                r_grant    <= w_pick;
                r_beat_cnt <= '0;
                if (w_pick == GRANT_DC) begin
                    r_addr <= from_dc_rd_req_addr;
                    r_len  <= from_dc_rd_req_len;
                end else begin
                    r_addr <= from_ic_rd_req_addr;
                    r_len  <= from_ic_rd_req_len;
                end
            end
            if (r_state == ST_RSP && w_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (from_mem_rd_rsp_last) begin
                    // Count excludes the last beat, so a correct burst has cnt == len.
                    if (r_beat_cnt != {1'b0, r_len}) begin
                        r_burst_err <= 1'b1;
                    end
                    r_rr_ptr <= r_grant;
                    r_grant  <= GRANT_NONE;
                end
            end
        end
    end

    assign burst_err = r_burst_err;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter.
// Directed sequences, a vector table and randomized transactions vs. a model.
module tb_mem_rd_arbiter;
    import mem_rd_arbiter_pkg::*;

    localparam int W_NONE = 0;
    localparam int W_IC   = 1;
    localparam int W_DC   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_v, ic_rdy, ic_rv, ic_rl, ic_rr;
    logic [31:0] ic_a, ic_rd;
    logic [7:0]  ic_l;
    logic        dc_v, dc_rdy, dc_rv, dc_rl, dc_rr;
    logic [31:0] dc_a, dc_rd;
    logic [7:0]  dc_l;
    logic        m_qv, m_qr, m_pv, m_pl, m_pr;
    logic [31:0] m_qa, m_pd;
    logic [7:0]  m_ql;
    logic        berr;

    int checks   = 0;
    int failures = 0;
    int m_rr     = W_IC;
    bit m_err    = 1'b0;

    always #5 clk = ~clk;

    mem_rd_arbiter dut (
        .clk                   (clk),
        .rst                   (rst),
        .from_ic_rd_req_valid  (ic_v),
        .from_ic_rd_req_addr   (ic_a),
        .from_ic_rd_req_len    (ic_l),
        .to_ic_rd_req_ready    (ic_rdy),
        .to_ic_rd_rsp_valid    (ic_rv),
        .to_ic_rd_rsp_data     (ic_rd),
        .to_ic_rd_rsp_last     (ic_rl),
        .from_ic_rd_rsp_ready  (ic_rr),
        .from_dc_rd_req_valid  (dc_v),
        .from_dc_rd_req_addr   (dc_a),
        .from_dc_rd_req_len    (dc_l),
        .to_dc_rd_req_ready    (dc_rdy),
        .to_dc_rd_rsp_valid    (dc_rv),
        .to_dc_rd_rsp_data     (dc_rd),
        .to_dc_rd_rsp_last     (dc_rl),
        .from_dc_rd_rsp_ready  (dc_rr),
        .to_mem_rd_req_valid   (m_qv),
        .to_mem_rd_req_addr    (m_qa),
        .to_mem_rd_req_len     (m_ql),
        .from_mem_rd_req_ready (m_qr),
        .from_mem_rd_rsp_valid (m_pv),
        .from_mem_rd_rsp_data  (m_pd),
        .from_mem_rd_rsp_last  (m_pl),
        .to_mem_rd_rsp_ready   (m_pr),
        .burst_err             (berr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input bit icv, input bit dcv);
        if (icv && dcv) return (m_rr == W_IC) ? W_DC : W_IC;
        if (icv) return W_IC;
        if (dcv) return W_DC;
        return W_NONE;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        ic_v = 0; ic_a = 0; ic_l = 0; ic_rr = 0;
        dc_v = 0; dc_a = 0; dc_l = 0; dc_rr = 0;
        m_qr = 0; m_pv = 0; m_pd = 0; m_pl = 0;
        tick();
        tick();
        rst = 1'b1;
        m_rr = W_IC;
        m_err = 1'b0;
        #1;
    endtask

    task automatic do_arb(input bit icv, input bit dcv,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [7:0] il, input logic [7:0] dl,
                          input int win);
        ic_v = icv; dc_v = dcv;
        ic_a = ia; dc_a = da; ic_l = il; dc_l = dl;
        #1;
        chk("ic_req_ready", ic_rdy, win == W_IC);
        chk("dc_req_ready", dc_rdy, win == W_DC);
        chk("idle_mem_req_valid", m_qv, 0);
        tick();
        if (win == W_IC) ic_v = 0;
        if (win == W_DC) dc_v = 0;
    endtask

    task automatic do_mem(input logic [31:0] a, input logic [7:0] l, input int dly);
        for (int i = 0; i <= dly; i++) begin
            m_qr = (i == dly);
            #1;
            chk("mem_req_valid", m_qv, 1);
            chk("mem_req_addr", m_qa, a);
            chk("mem_req_len", m_ql, l);
            chk("busy_req_ready", {ic_rdy, dc_rdy}, 0);
            tick();
        end
        m_qr = 0;
    endtask

    task automatic set_rr(input int win, input bit r);
        ic_rr = (win == W_IC) ? r : ~r;
        dc_rr = (win == W_DC) ? r : ~r;
    endtask

    task automatic chk_route(input int win, input logic [31:0] d, input bit last);
        if (win == W_IC) begin
            chk("ic_rsp_valid", ic_rv, 1);
            chk("ic_rsp_data", ic_rd, d);
            chk("ic_rsp_last", ic_rl, last);
            chk("dc_rsp_valid_off", dc_rv, 0);
            chk("dc_rsp_data_off", dc_rd, 0);
        end else begin
            chk("dc_rsp_valid", dc_rv, 1);
            chk("dc_rsp_data", dc_rd, d);
            chk("dc_rsp_last", dc_rl, last);
            chk("ic_rsp_valid_off", ic_rv, 0);
            chk("ic_rsp_data_off", ic_rd, 0);
        end
    endtask

    task automatic do_rsp(input int win, input logic [7:0] l, input int last_at,
                          input int stall_b, input int stall_n, input logic [31:0] base);
        int n;
        n = 0;
        for (int b = 0; b <= last_at; b++) begin
            m_pv = 1;
            m_pd = base + b;
            m_pl = (b == last_at);
            if (b == stall_b) begin
                for (int s = 0; s < stall_n; s++) begin
                    set_rr(win, 0);
                    #1;
                    chk("stall_mem_rsp_ready", m_pr, 0);
                    chk_route(win, base + b, b == last_at);
                    tick();
                end
            end
            set_rr(win, 1);
            #1;
            chk("mem_rsp_ready", m_pr, 1);
            chk_route(win, base + b, b == last_at);
            n++;
            tick();
        end
        m_pv = 0; m_pl = 0; ic_rr = 0; dc_rr = 0;
        m_rr = win;
        if (n != int'(l) + 1) m_err = 1'b1;
        #1;
        chk("burst_err", berr, m_err);
        chk("idle_mem_rsp_ready", m_pr, 1);
    endtask

    typedef struct {
        bit icv;
        bit dcv;
        bit eic;
        bit edc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #400000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int w, ll, la;
        logic [31:0] ra, rb;
        logic [7:0] rl_ic, rl_dc, wl;
        bit ricv, rdcv;

        do_reset();
        chk("rst_ic_req_ready", ic_rdy, 0);
        chk("rst_dc_req_ready", dc_rdy, 0);
        chk("rst_mem_req_valid", m_qv, 0);
        chk("rst_ic_rsp_valid", ic_rv, 0);
        chk("rst_dc_rsp_valid", dc_rv, 0);
        chk("rst_mem_rsp_ready", m_pr, 1);
        chk("rst_burst_err", berr, 0);

        // DC-only burst
        do_arb(0, 1, 0, 32'h0000_0120, 0, LEN_BURST, W_DC);
        do_mem(32'h120, 8'd7, 0);
        do_rsp(W_DC, 8'd7, 7, -1, 0, 32'hA0);

        // Tie after reset: DC first, IC in the next IDLE cycle
        do_reset();
        do_arb(1, 1, 32'h0000_0040, 32'h8000_0004, LEN_BURST, LEN_SINGLE, W_DC);
        do_mem(32'h8000_0004, 8'd0, 1);
        do_rsp(W_DC, 8'd0, 0, -1, 0, 32'h55);
        do_arb(1, 0, 32'h0000_0040, 0, LEN_BURST, 0, W_IC);
        do_mem(32'h40, 8'd7, 0);
        do_rsp(W_IC, 8'd7, 7, -1, 0, 32'h100);

        // DC stalls 3 cycles mid-burst
        do_arb(0, 1, 0, 32'h200, 0, LEN_BURST, W_DC);
        do_mem(32'h200, 8'd7, 2);
        do_rsp(W_DC, 8'd7, 7, 3, 3, 32'hB0);

        // Early last -> sticky error
        do_arb(0, 1, 0, 32'h300, 0, LEN_BURST, W_DC);
        do_mem(32'h300, 8'd7, 0);
        do_rsp(W_DC, 8'd7, 4, -1, 0, 32'hC0);
        do_arb(1, 0, 32'h340, 0, LEN_SINGLE, 0, W_IC);
        do_mem(32'h340, 8'd0, 0);
        do_rsp(W_IC, 8'd0, 0, -1, 0, 32'hC8);

        // Reset during beat 3 of a DC burst
        do_arb(0, 1, 0, 32'h400, 0, LEN_BURST, W_DC);
        do_mem(32'h400, 8'd7, 0);
        for (int b = 0; b < 3; b++) begin
            m_pv = 1; m_pd = 32'hD0 + b; m_pl = 0; dc_rr = 1;
            #1;
            chk_route(W_DC, 32'hD0 + b, 0);
            tick();
        end
        m_pd = 32'hD3;
        rst = 1'b0;
        #1;
        chk("rstmid_dc_rsp_valid", dc_rv, 0);
        chk("rstmid_ic_rsp_valid", ic_rv, 0);
        tick();
        rst = 1'b1;
        m_rr = W_IC;
        m_err = 1'b0;
        #1;
        chk("rstmid_mem_rsp_ready", m_pr, 1);
        chk("rstmid_drop_dc_valid", dc_rv, 0);
        chk("rstmid_drop_ic_valid", ic_rv, 0);
        chk("rstmid_mem_req_valid", m_qv, 0);
        chk("rstmid_burst_err", berr, 0);
        m_pv = 0; dc_rr = 0;
        do_arb(1, 1, 32'h500, 32'h600, LEN_SINGLE, LEN_SINGLE, W_DC);
        do_mem(32'h600, 8'd0, 0);
        do_rsp(W_DC, 8'd0, 0, -1, 0, 32'hE0);

        // Arbitration table from reset (rr_ptr = IC)
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w = tbl[i].eic ? W_IC : (tbl[i].edc ? W_DC : W_NONE);
            ra = 32'h1000 + 32'(i) * 16;
            rb = 32'h2000 + 32'(i) * 16;
            do_arb(tbl[i].icv, tbl[i].dcv, ra, rb, LEN_SINGLE, LEN_SINGLE, w);
            if (w == W_NONE) begin
                #1;
                chk("tbl_none_mem_req_valid", m_qv, 0);
            end else begin
                do_mem((w == W_IC) ? ra : rb, 8'd0, 0);
                do_rsp(w, 8'd0, 0, -1, 0, 32'hF00 + 32'(i));
            end
        end

        // Randomized transactions vs. transaction-level model
        for (int t = 0; t < 40; t++) begin
            ricv = 1'($urandom_range(0, 1));
            rdcv = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            ll = $urandom_range(0, 3);
            rl_ic = (ll == 0) ? LEN_SINGLE : (ll == 1) ? LEN_BURST : 8'($urandom_range(0, 3));
            ll = $urandom_range(0, 3);
            rl_dc = (ll == 0) ? LEN_SINGLE : (ll == 1) ? LEN_BURST : 8'($urandom_range(0, 3));
            w = model_pick(ricv, rdcv);
            do_arb(ricv, rdcv, ra, rb, rl_ic, rl_dc, w);
            if (w == W_NONE) begin
                #1;
                chk("rnd_none_mem_req_valid", m_qv, 0);
            end else begin
                wl = (w == W_IC) ? rl_ic : rl_dc;
                la = ($urandom_range(0, 9) < 8) ? int'(wl) : $urandom_range(0, int'(wl) + 2);
                do_mem((w == W_IC) ? ra : rb, wl, $urandom_range(0, 2));
                do_rsp(w, wl, la, $urandom_range(0, la + 1), $urandom_range(0, 2), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Arbitrates the I-Cache and D-Cache memory read channels onto the single memory read channel, one transaction at a time.
- Sits directly downstream of dcache_top's to_mem_rd_* / from_mem_rd_* ports and of the matching icache ports; the memory read port sits downstream of this block.
- Routes the whole response burst back to the granted cache, and flags burst-length violations.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data beat width.
- LEN_W, 8, burst length field width (beats minus 1).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset: synchronous, active-low (asserted when 0), sampled on posedge clk.
- from_ic_rd_req_valid/_addr/_len  input  1/ADDR_W/LEN_W  I-Cache read request.
- to_ic_rd_req_ready  output  1  request accepted.
- to_ic_rd_rsp_valid/_data/_last  output  1/DATA_W/1  beat returned to I-Cache.
- from_ic_rd_rsp_ready  input  1  I-Cache accepts beat.
- from_dc_rd_req_valid/_addr/_len  input  1/ADDR_W/LEN_W  D-Cache read request.
- to_dc_rd_req_ready  output  1  request accepted.
- to_dc_rd_rsp_valid/_data/_last  output  1/DATA_W/1  beat returned to D-Cache.
- from_dc_rd_rsp_ready  input  1  D-Cache accepts beat.
- to_mem_rd_req_valid/_addr/_len  output  1/ADDR_W/LEN_W  request to memory.
- from_mem_rd_req_ready  input  1  memory accepts request.
- from_mem_rd_rsp_valid/_data/_last  input  1/DATA_W/1  beat from memory.
- to_mem_rd_rsp_ready  output  1  arbiter accepts beat.
- burst_err  output  1  sticky: last beat count did not match len+1.

Behaviour:
- Reset values (rst==0): state=IDLE, grant=none, rr_ptr=IC (so DC wins first tie), beat_cnt=0, burst_err=0, all req/rsp valids and req_readys 0, to_mem_rd_rsp_ready=1 (drains stale beats).
- Reset mid-burst: abandons the transaction; nothing is forwarded upstream.
- States: IDLE, REQ, RSP; one-hot; no other states.
- IDLE:
  - If exactly one *_rd_req_valid is high, grant it.
  - If both are high, grant the one not pointed to by rr_ptr.
  - Winner's to_*_rd_req_ready=1 combinationally in this cycle; loser's ready=0.
  - Latch grant, addr, len; beat_cnt<=0; go to REQ.
  - No valid: stay in IDLE; all readys 0.
- REQ:
  - to_mem_rd_req_valid=1, with addr/len from the latch (stable until accepted).
  - from_mem_rd_req_ready=1: go to RSP. Otherwise hold.
- RSP:
  - to_mem_rd_rsp_ready = granted cache's rsp_ready.
  - Granted cache sees rsp_valid = from_mem_rd_rsp_valid, plus data and last passed through combinationally (zero latency).
  - Non-granted cache sees valid=0 and data=0.
  - Each handshake (valid&&ready): beat_cnt++ (LEN_W+1 bits, no wrap for len<=255).
  - Handshake with last=1: if beat_cnt != latched len, set burst_err (sticky until reset). rr_ptr<=grant; grant<=none; go to IDLE.
- Arbiter latency: request accepted in the same cycle as the grant; memory request appears the next cycle.
- Simultaneous events:
  - A new request arriving during REQ/RSP waits; its ready stays 0.
  - A request that deasserts in IDLE before grant is never granted.
- Extra beats after last with no grant: in IDLE, to_mem_rd_rsp_ready=1 and beats are dropped.
- Outputs to memory are stable while valid && !ready.

Decomposition:
- Shared package constants:
  - state encodings (IDLE/REQ/RSP);
  - GRANT_NONE/GRANT_IC/GRANT_DC encodings;
  - LEN_BURST=8'd7 and LEN_SINGLE=8'd0 (shared with dcache_top and icache).
- One natural sub-module: rr_arb2 (2-input round-robin picker; inputs: two valids, rr_ptr; output: one-hot grant).

Test Plan:
- DC-only read, addr 0x0000_0120, len 7; memory ready immediately, 8 beats 0xA0..0xA7 -> to_mem addr 0x120 len 7 one cycle after grant; D-Cache gets 8 beats with last on 0xA7; I-Cache valid stays 0; burst_err=0.
- Both valid after reset (IC 0x0000_0040 len 7, DC 0x8000_0004 len 0) -> DC granted first (single beat 0x55); IC granted in the IDLE cycle after DC's last.
- DC holds rsp_ready=0 for 3 cycles mid-burst -> to_mem_rd_rsp_ready=0 for those cycles; beat data held; beat count ends at exactly 8.
- Memory asserts last on the 5th beat of a len-7 burst -> burst_err=1, state returns to IDLE, burst_err stays 1 until rst=0.
- rst=0 for one cycle during RSP beat 3 -> next cycle IDLE, all valids 0, to_mem_rd_rsp_ready=1, rr_ptr=IC.
